// File: rtl/mux16_rr_sched_if.sv
// Request/grant bundle between the requesters and the 16:1 mux round-robin scheduler.
// master = requester side, slave = scheduler side.
interface mux16_rr_sched_if;
  logic [15:0] Req;
  logic        Done;
  logic [3:0]  Sel;
  logic [15:0] Grant;
  logic        Valid;
  logic        Timeout;

  modport master (
    output Req,
    output Done,
    input  Sel,
    input  Grant,
    input  Valid,
    input  Timeout
  );

  modport slave (
    input  Req,
    input  Done,
    output Sel,
    output Grant,
    output Valid,
    output Timeout
  );
endinterface

// File: rtl/mux16_rr_sched.sv
// Round-robin scheduler for a shared 16:1 mux: grants one requester at a time, holds the select.
// Optional forced release after MAX_HOLD cycles when built with SCHED_TIMEOUT_EN.
module mux16_rr_sched #(
  parameter int unsigned MAX_HOLD = 15,
  parameter int unsigned CNT_W    = 8
) (
  input logic               Clock,
  input logic               Resetn,
  mux16_rr_sched_if.slave   sched_io
);

  if (MAX_HOLD < 1 || MAX_HOLD > 255 || (64'(1) << CNT_W) <= 64'(MAX_HOLD)) begin : g_param_err
    $error("mux16_rr_sched: MAX_HOLD must be 1..255 and fit in CNT_W bits");
  end

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e      state_q, state_d;
  logic [3:0]  sel_q, sel_d;
  logic [3:0]  ptr_q, ptr_d;
  logic [15:0] grant_q, grant_d;
  logic        valid_q, valid_d;

  logic        pick_found;
  logic [3:0]  pick_idx;
  logic        release_hard;
  logic        timeout_hit;
  logic        release_req;

  // Scan from highest offset down so the first set bit after ptr_q is the last one written.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = ptr_q;
    for (int i = 15; i >= 0; i--) begin
      if (sched_io.Req[ptr_q + 4'(i)]) begin
        pick_found = 1'b1;
        pick_idx   = ptr_q + 4'(i);
      end
    end
  end

  assign release_hard = sched_io.Done || !sched_io.Req[sel_q];

`ifdef SCHED_TIMEOUT_EN
  logic [CNT_W-1:0] hold_q, hold_d;

  assign timeout_hit = (state_q == StBusy) && !release_hard &&
                       (hold_q == CNT_W'(MAX_HOLD - 1));

  always_comb begin
    hold_d = hold_q;
    if (state_q == StIdle) begin
      if (pick_found) begin
        hold_d = '0;
      end
    end else if (!release_req) begin
      hold_d = hold_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  assign release_req = (state_q == StBusy) && (release_hard || timeout_hit);

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q <= StIdle;
      sel_q   <= 4'd0;
      ptr_q   <= 4'd0;
      grant_q <= 16'h0000;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (pick_found) state_d = StBusy;
      StBusy: if (release_req) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Sel survives release; only Grant/Valid drop so the mux select stays stable while idle.
  always_comb begin
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    valid_d = valid_q;
    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          sel_d   = pick_idx;
          grant_d = 16'h0001 << pick_idx;
          valid_d = 1'b1;
        end
      end
      StBusy: begin
        if (release_req) begin
          grant_d = 16'h0000;
          valid_d = 1'b0;
          ptr_d   = sel_q + 4'd1;
        end
      end
      default: begin
        grant_d = 16'h0000;
        valid_d = 1'b0;
      end
    endcase
  end

  assign sched_io.Sel     = sel_q;
  assign sched_io.Grant   = grant_q;
  assign sched_io.Valid   = valid_q;
  assign sched_io.Timeout = timeout_hit && Resetn;

endmodule

// File: tb/tb_mux16_rr_sched.sv
// Self-checking bench for mux16_rr_sched: directed scenarios plus random traffic vs a cycle model.
module tb_mux16_rr_sched;

  localparam int unsigned MaxHold = 4;
`ifdef SCHED_TIMEOUT_EN
  localparam bit TimeoutEn = 1'b1;
`else
  localparam bit TimeoutEn = 1'b0;
`endif

  logic Clock  = 1'b0;
  logic Resetn = 1'b0;

  mux16_rr_sched_if bus ();

  mux16_rr_sched #(
    .MAX_HOLD (MaxHold),
    .CNT_W    (8)
  ) dut (
    .Clock    (Clock),
    .Resetn   (Resetn),
    .sched_io (bus)
  );

  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;

  // Reference model: who holds the grant, where the search starts, how many cycles it has been shown.
  bit          m_busy = 1'b0;
  int          m_sel  = 0;
  int          m_ptr  = 0;
  int          m_held = 0;
  bit          exp_to;
  logic        obs_to;
  bit          exp_valid;
  logic [3:0]  exp_sel;
  logic [15:0] exp_grant;

  // Drives one clock cycle and advances the model; callers do the comparisons.
  task automatic drive_cycle(input logic [15:0] req, input logic done);
    bit rel_normal;
    bit found;
    bus.Req  = req;
    bus.Done = done;
    #1;
    obs_to     = bus.Timeout;
    rel_normal = done || !req[m_sel];
    exp_to     = Resetn && m_busy && !rel_normal && TimeoutEn && (m_held == int'(MaxHold));
    @(posedge Clock);
    if (!Resetn) begin
      m_busy = 1'b0;
      m_sel  = 0;
      m_ptr  = 0;
      m_held = 0;
    end else if (m_busy) begin
      if (rel_normal || exp_to) begin
        m_busy = 1'b0;
        m_ptr  = (m_sel + 1) % 16;
      end else begin
        m_held++;
      end
    end else if (req != 16'h0000) begin
      found = 1'b0;
      for (int k = 0; k < 16; k++) begin
        if (!found && req[(m_ptr + k) % 16]) begin
          found = 1'b1;
          m_sel = (m_ptr + k) % 16;
        end
      end
      m_busy = 1'b1;
      m_held = 1;
    end
    #1;
    exp_valid = m_busy;
    exp_sel   = 4'(m_sel);
    exp_grant = m_busy ? (16'h0001 << m_sel) : 16'h0000;
  endtask

  task automatic test_reset();
    Resetn = 1'b0;
    drive_cycle(16'hFFFF, 1'b0);
    drive_cycle(16'hFFFF, 1'b0);
    checks++;
    if (bus.Valid !== 1'b0 || bus.Grant !== 16'h0000 || bus.Sel !== 4'd0 || obs_to !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: valid=%b grant=%h sel=%0d timeout=%b, required 0/0000/0/0",
               bus.Valid, bus.Grant, bus.Sel, obs_to);
    end
    Resetn = 1'b1;
    for (int c = 0; c < 10; c++) begin
      drive_cycle(16'h0000, (c % 2) == 1);
      checks++;
      if (bus.Valid !== 1'b0 || bus.Grant !== 16'h0000 || bus.Sel !== 4'd0) begin
        errors++;
        $display("FAIL idle_no_req cycle %0d: valid=%b grant=%h sel=%0d, required 0/0000/0",
                 c, bus.Valid, bus.Grant, bus.Sel);
      end
    end
  endtask

  // Grant Sel=5, hold, then Done in the 4th valid cycle (normal release even when it hits timeout).
  task automatic test_single_grant();
    drive_cycle(16'h0020, 1'b0);
    checks++;
    if (bus.Valid !== 1'b1 || bus.Sel !== 4'd5 || bus.Grant !== 16'h0020) begin
      errors++;
      $display("FAIL single_grant: valid=%b sel=%0d grant=%h, required 1/5/0020",
               bus.Valid, bus.Sel, bus.Grant);
    end
    for (int c = 0; c < 3; c++) begin
      drive_cycle(16'h0020, 1'b0);
      checks++;
      if (bus.Valid !== 1'b1 || bus.Sel !== 4'd5 || bus.Grant !== 16'h0020 || obs_to !== 1'b0) begin
        errors++;
        $display("FAIL single_hold cycle %0d: valid=%b sel=%0d grant=%h timeout=%b, required 1/5/0020/0",
                 c, bus.Valid, bus.Sel, bus.Grant, obs_to);
      end
    end
    drive_cycle(16'h0020, 1'b1);
    checks++;
    if (bus.Valid !== 1'b0 || bus.Grant !== 16'h0000 || bus.Sel !== 4'd5 || obs_to !== 1'b0) begin
      errors++;
      $display("FAIL single_release: valid=%b grant=%h sel=%0d timeout=%b, required 0/0000/5/0",
               bus.Valid, bus.Grant, bus.Sel, obs_to);
    end
  endtask

  task automatic test_fairness();
    Resetn = 1'b0;
    drive_cycle(16'h0000, 1'b0);
    Resetn = 1'b1;
    for (int g = 0; g < 17; g++) begin
      drive_cycle(16'hFFFF, 1'b1);
      checks++;
      if (bus.Valid !== 1'b1 || bus.Sel !== 4'(g % 16) || bus.Grant !== (16'h0001 << (g % 16))) begin
        errors++;
        $display("FAIL fairness grant %0d: valid=%b sel=%0d grant=%h, required 1/%0d/%h",
                 g, bus.Valid, bus.Sel, bus.Grant, g % 16, 16'h0001 << (g % 16));
      end
      drive_cycle(16'hFFFF, 1'b1);
      checks++;
      if (bus.Valid !== 1'b0 || bus.Grant !== 16'h0000) begin
        errors++;
        $display("FAIL fairness gap %0d: valid=%b grant=%h, required 0/0000", g, bus.Valid, bus.Grant);
      end
    end
  endtask

  // From Ptr=6, Req=0x11 must wrap to 0; withdrawing bit 0 then hands over to 4.
  task automatic test_withdraw();
    Resetn = 1'b0;
    drive_cycle(16'h0000, 1'b0);
    Resetn = 1'b1;
    drive_cycle(16'h0020, 1'b0);
    drive_cycle(16'h0020, 1'b1);
    drive_cycle(16'h0011, 1'b0);
    checks++;
    if (bus.Valid !== 1'b1 || bus.Sel !== 4'd0 || bus.Grant !== 16'h0001) begin
      errors++;
      $display("FAIL withdraw_wrap: valid=%b sel=%0d grant=%h, required 1/0/0001",
               bus.Valid, bus.Sel, bus.Grant);
    end
    drive_cycle(16'h0010, 1'b0);
    checks++;
    if (bus.Valid !== 1'b0 || bus.Grant !== 16'h0000) begin
      errors++;
      $display("FAIL withdraw_release: valid=%b grant=%h, required 0/0000", bus.Valid, bus.Grant);
    end
    drive_cycle(16'h0010, 1'b0);
    checks++;
    if (bus.Valid !== 1'b1 || bus.Sel !== 4'd4 || bus.Grant !== 16'h0010) begin
      errors++;
      $display("FAIL withdraw_next: valid=%b sel=%0d grant=%h, required 1/4/0010",
               bus.Valid, bus.Sel, bus.Grant);
    end
  endtask

  task automatic test_reset_mid_grant();
    drive_cycle(16'h0000, 1'b1);
    drive_cycle(16'h0200, 1'b0);
    checks++;
    if (bus.Valid !== 1'b1 || bus.Sel !== 4'd9) begin
      errors++;
      $display("FAIL midreset_setup: valid=%b sel=%0d, required 1/9", bus.Valid, bus.Sel);
    end
    Resetn = 1'b0;
    drive_cycle(16'h0200, 1'b0);
    checks++;
    if (bus.Valid !== 1'b0 || bus.Grant !== 16'h0000 || bus.Sel !== 4'd0) begin
      errors++;
      $display("FAIL midreset_drop: valid=%b grant=%h sel=%0d, required 0/0000/0",
               bus.Valid, bus.Grant, bus.Sel);
    end
    Resetn = 1'b1;
    drive_cycle(16'h0200, 1'b0);
    checks++;
    if (bus.Valid !== 1'b1 || bus.Sel !== 4'd9 || bus.Grant !== 16'h0200) begin
      errors++;
      $display("FAIL midreset_regrant: valid=%b sel=%0d grant=%h, required 1/9/0200",
               bus.Valid, bus.Sel, bus.Grant);
    end
  endtask

  // Continuous single requester with no Done: held forever, or timed out every MaxHold cycles.
  task automatic test_hold_timeout();
    int pulses = 0;
    int exp_pulses = 0;
    Resetn = 1'b0;
    drive_cycle(16'h0000, 1'b0);
    Resetn = 1'b1;
    for (int c = 0; c < 16; c++) begin
      drive_cycle(16'h0008, 1'b0);
      if (obs_to === 1'b1) pulses++;
      if (exp_to) exp_pulses++;
      checks++;
      if (bus.Valid !== exp_valid || bus.Sel !== exp_sel || bus.Grant !== exp_grant ||
          obs_to !== exp_to) begin
        errors++;
        $display("FAIL hold cycle %0d: valid=%b sel=%0d grant=%h timeout=%b, required %b/%0d/%h/%b",
                 c, bus.Valid, bus.Sel, bus.Grant, obs_to, exp_valid, exp_sel, exp_grant, exp_to);
      end
    end
    checks++;
    if (pulses != exp_pulses) begin
      errors++;
      $display("FAIL timeout_pulses: counted %0d, required %0d", pulses, exp_pulses);
    end
  endtask

  task automatic test_random();
    logic [15:0] req;
    logic        done;
    for (int c = 0; c < 600; c++) begin
      Resetn = ($urandom_range(0, 59) != 0);
      req    = 16'($urandom) & 16'($urandom);
      if (m_busy && $urandom_range(0, 3) != 0) req[m_sel] = 1'b1;
      done   = ($urandom_range(0, 4) == 0);
      drive_cycle(req, done);
      checks++;
      if (bus.Valid !== exp_valid || bus.Sel !== exp_sel || bus.Grant !== exp_grant ||
          obs_to !== exp_to) begin
        errors++;
        $display("FAIL random cycle %0d: valid=%b sel=%0d grant=%h timeout=%b, required %b/%0d/%h/%b",
                 c, bus.Valid, bus.Sel, bus.Grant, obs_to, exp_valid, exp_sel, exp_grant, exp_to);
      end
      checks++;
      if ((bus.Grant & (bus.Grant - 16'h0001)) != 16'h0000 || ((bus.Grant == 16'h0000) == bus.Valid)) begin
        errors++;
        $display("FAIL grant_onehot cycle %0d: grant=%h valid=%b, required one-hot iff valid",
                 c, bus.Grant, bus.Valid);
      end
    end
    Resetn = 1'b1;
  endtask

  initial begin
    bus.Req  = 16'h0000;
    bus.Done = 1'b0;
    Resetn   = 1'b0;
    @(posedge Clock);
    #1;
    test_reset();
    test_single_grant();
    test_fairness();
    test_withdraw();
    test_reset_mid_grant();
    test_hold_timeout();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
